// File: rtl/prio_pkg.sv
// prio_pkg: shared FSM state and arbitration mode encodings
package prio_pkg;
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational winner select, fixed-highest or round-robin from start
module prio_pick
    import prio_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic [W-1:0] index,
    output logic         any
);
    // last match wins: fixed scans upward (highest index), rr scans offsets downward (nearest to start)
    always_comb begin
        logic [W-1:0] j;
        j = '0;
        index = '0;
        any = |eligible;
        if (mode == MODE_RR) begin
            for (int k = N - 1; k >= 0; k--) begin
                j = W'((int'(start) + k) % N);
                if (eligible[j]) index = j;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                j = W'(i);
                if (eligible[j]) index = j;
            end
        end
    end
endmodule

// File: rtl/prio_arbiter_n.sv
// prio_arbiter_n: edge-triggered pending-request arbiter with fixed/round-robin offer handshake
module prio_arbiter_n
    import prio_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         rr_mode,
    output logic [W-1:0] grant_id,
    output logic         grant_valid,
    input  logic         grant_ready,
    output logic [N-1:0] pending
);
    state_t       state_q, state_d;
    logic [N-1:0] req_q, req_d, pending_q, pending_d, rise, clr, eligible;
    logic [W-1:0] grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, pick_idx;
    logic         armed_q, pick_any;

    assign eligible    = pending_q & ~mask;
    assign grant_valid = (state_q == OFFER);
    assign grant_id    = grant_id_q;
    assign pending     = pending_q;

    prio_pick #(.N(N), .W(W)) u_pick (
        .eligible (eligible),
        .start    (rr_ptr_q),
        .mode     (rr_mode),
        .index    (pick_idx),
        .any      (pick_any)
    );

    // edge detect is disarmed for the first edge after reset so a held req does not re-pend
    always_comb begin
        req_d = req;
        rise = req & ~req_q & {N{armed_q}};
        clr = '0;
        if (state_q == OFFER && grant_ready) clr[grant_id_q] = 1'b1;
        pending_d = (pending_q & ~clr) | rise;
    end

    // IDLE picks and latches a winner; OFFER holds it until the handshake
    always_comb begin
        state_d = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE) begin
            if (pick_any) begin
                state_d = OFFER;
                grant_id_d = pick_idx;
            end
        end else if (grant_ready) begin
            state_d = IDLE;
            if (rr_mode == MODE_RR)
                rr_ptr_d = (grant_id_q == W'(N - 1)) ? '0 : grant_id_q + W'(1);
        end
    end

    // state registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            pending_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pending_q  <= pending_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            armed_q    <= 1'b1;
        end
    end
endmodule

// File: doc/prio_arbiter_n.md
PRIO_ARBITER_N -- requirements
Module: prio_arbiter_n

Interface
REQ-001 SHALL have parameter N, default 8: number of request channels; legal range 2..64.
REQ-002 SHALL have derived parameter W, default $clog2(N): width of the channel index.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port req  input  N: request lines; req[N-1] is the highest fixed priority.
REQ-006 SHALL have port mask  input  N: per-channel mask; 1 = channel not eligible.
REQ-007 SHALL have port rr_mode  input  1: 0 = fixed priority, 1 = round-robin.
REQ-008 SHALL have port grant_id  output  W: index of the offered channel.
REQ-009 SHALL have port grant_valid  output  1: grant_id is valid.
REQ-010 SHALL have port grant_ready  input  1: consumer accepts the grant.
REQ-011 SHALL have port pending  output  N: registered pending-request vector.

Function
REQ-012 SHALL register req into req_q each cycle; a rising edge is req[i] & ~req_q[i].
REQ-013 SHALL set pending[i] on the clock edge that samples a rising edge of req[i].
REQ-014 SHALL clear pending[i] on the edge where grant_valid & grant_ready & grant_id==i.
REQ-015 SHALL let a set win over a clear when both hit pending[i] in the same cycle.
REQ-016 SHALL define eligible = pending & ~mask, evaluated combinationally.
REQ-017 SHALL implement FSM states IDLE and OFFER.
REQ-018 SHALL stay in IDLE while eligible == 0.
REQ-019 SHALL, in IDLE with eligible != 0, load the winner into grant_id, set grant_valid and enter OFFER on the next edge.
REQ-020 SHALL, in fixed mode, select the highest set index of eligible.
REQ-021 SHALL, in round-robin mode, select the first set bit of eligible searching upward from rr_ptr and wrapping N-1 -> 0.
REQ-022 SHALL hold grant_id and grant_valid stable in OFFER until grant_ready is sampled high, regardless of changes to mask, req or rr_mode.
REQ-023 SHALL, on the OFFER handshake, clear grant_valid, load rr_ptr with (grant_id+1) mod N and return to IDLE; rr_ptr SHALL not update in fixed mode.
REQ-024 SHALL deassert grant_valid for at least one cycle between grants; peak throughput is one grant per two cycles.
REQ-025 SHALL give latency of 2 rising edges from req[i] first sampled high to grant_valid high when idle and unmasked.
REQ-026 SHALL keep a masked pending bit set and make it eligible as soon as its mask bit falls.
REQ-027 SHALL apply rr_mode changes at the next IDLE selection only.

Reset
REQ-028 SHALL asynchronously force req_q=0, pending=0, grant_valid=0, grant_id=0, rr_ptr=0 and state=IDLE while rst is high.
REQ-029 SHALL drop any in-flight grant on reset without completing its handshake; a req held high through reset SHALL not re-pend unless it falls and rises again.

Structure
REQ-030 SHALL place the FSM state enum and the mode encoding constants in shared package prio_pkg.
REQ-031 SHALL implement the rotate-and-pick logic in one combinational sub-module prio_pick with inputs eligible, start index and mode, and outputs index and any.
REQ-032 SHALL keep all registers in prio_arbiter_n; prio_pick SHALL contain no state.

Verification (N=8)
REQ-033 SHALL cover: fixed mode, req=8'b0010_0100 rising together, ready=1 -> grants 5, then 2; pending returns to 0.
REQ-034 SHALL cover: rr_mode=1, req=8'hFF rising once, ready=1 -> grants 0,1,2,...,7 in order, one every 2 cycles.
REQ-035 SHALL cover: mask=8'h80 with req[7] edge -> no grant; on mask=0, grant_id=7 on the next cycle.
REQ-036 SHALL cover: OFFER with grant_id=3, ready=0 for 5 cycles while mask=8'hFF -> grant_id and grant_valid stay stable; on ready=1, pending[3] clears.
REQ-037 SHALL cover: new req[3] edge in the same cycle as the grant-3 handshake -> pending[3] remains 1 and channel 3 is granted again.
REQ-038 SHALL cover: rst pulsed mid-OFFER -> grant_valid=0 and pending=0 immediately, with no clock edge needed, and rr_ptr=0 afterwards.
